l2_memory_bridge: RTL



---
 rtl/l2_memory_bridge.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/l2_memory_bridge.sv
// l2_memory_bridge: turns cache-hierarchy memory messages into single-line
// valid/ready memory transactions and injects memory-side line flushes.
//
// Build option: define L2_MEM_BRIDGE_WB_ACK_EN to acknowledge hierarchy
// writes with a one-cycle MEM_RESP (data 0). Flush writes never ack.
//
// Ports:
//   clock, reset                 clock, async active-high reset
//   cachehier2mem_{msg,address,data}   request from the hierarchy
//   mem2cachehier_{msg,address,data}   response/flush request to it
//   mem_intf_busy                transaction in progress
//   mem_intf_address(_valid)     line currently being serviced
//   mem_req_{valid,write,address,data}, mem_req_ready  memory request
//   mem_resp_{valid,data}        in-order read data from memory
//   ext_flush_{valid,address}    external flush request
//   ext_flush_ready              flush accepted (one-cycle pulse)
//   ext_flush_done               flushed line written (one-cycle pulse)
//
// Message encodings mirror the hierarchy's shared params include.

module l2_memory_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MSG_BITS     = 4,
  parameter int OFFSET_BITS  = 2,
  localparam int L2_WIDTH    = DATA_WIDTH << OFFSET_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cachehier2mem_msg,
  input  logic [ADDRESS_BITS-1:0] cachehier2mem_address,
  input  logic [L2_WIDTH-1:0]     cachehier2mem_data,
  output logic [MSG_BITS-1:0]     mem2cachehier_msg,
  output logic [ADDRESS_BITS-1:0] mem2cachehier_address,
  output logic [L2_WIDTH-1:0]     mem2cachehier_data,
  output logic                    mem_intf_busy,
  output logic [ADDRESS_BITS-1:0] mem_intf_address,
  output logic                    mem_intf_address_valid,
  output logic                    mem_req_valid,
  output logic                    mem_req_write,
  output logic [ADDRESS_BITS-1:0] mem_req_address,
  output logic [L2_WIDTH-1:0]     mem_req_data,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [L2_WIDTH-1:0]     mem_resp_data,
  input  logic                    ext_flush_valid,
  input  logic [ADDRESS_BITS-1:0] ext_flush_address,
  output logic                    ext_flush_ready,
  output logic                    ext_flush_done
);

  localparam logic [MSG_BITS-1:0] NO_REQ    = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ     = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ    = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] FLUSH     = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] RFO_BCAST = MSG_BITS'(6);
  localparam logic [MSG_BITS-1:0] C_WB      = MSG_BITS'(7);
  localparam logic [MSG_BITS-1:0] C_FLUSH   = MSG_BITS'(8);
  localparam logic [MSG_BITS-1:0] MEM_RESP  = MSG_BITS'(10);
  localparam logic [MSG_BITS-1:0] REQ_FLUSH = MSG_BITS'(11);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP,
    FL_REQ,
    FL_WAIT,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [L2_WIDTH-1:0]     wdata_q, wdata_d;
  logic [L2_WIDTH-1:0]     rline_q, rline_d;
  logic                    flush_q, flush_d;

  logic [MSG_BITS-1:0]     msg_q, msg_d;
  logic [ADDRESS_BITS-1:0] oaddr_q, oaddr_d;
  logic [L2_WIDTH-1:0]     odata_q, odata_d;
  logic                    busy_q, busy_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rwrite_q, rwrite_d;
  logic [ADDRESS_BITS-1:0] raddr_q, raddr_d;
  logic [L2_WIDTH-1:0]     rdata_q, rdata_d;
  logic                    fl_rdy_q, fl_rdy_d;
  logic                    fl_done_q, fl_done_d;

  logic hier_rd;
  logic hier_wr;
  logic fl_match;

  assign hier_rd = (cachehier2mem_msg == R_REQ)
                || (cachehier2mem_msg == RFO_BCAST);
  assign hier_wr = (cachehier2mem_msg == WB_REQ)
                || (cachehier2mem_msg == C_WB)
                || (cachehier2mem_msg == FLUSH)
                || (cachehier2mem_msg == C_FLUSH);
  assign fl_match = (cachehier2mem_msg == C_FLUSH)
                 && (cachehier2mem_address == addr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rline_d   = rline_q;
    flush_d   = flush_q;
    fl_rdy_d  = 1'b0;
    fl_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hier_rd) begin
          addr_d  = cachehier2mem_address;
          flush_d = 1'b0;
          state_d = RD_ISSUE;
        end else if (hier_wr) begin
          addr_d  = cachehier2mem_address;
          wdata_d = cachehier2mem_data;
          flush_d = 1'b0;
          state_d = WR_ISSUE;
        end else if (ext_flush_valid) begin
          addr_d   = ext_flush_address;
          fl_rdy_d = 1'b1;
          state_d  = FL_REQ;
        end
      end
      RD_ISSUE: begin
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          rline_d = mem_resp_data;
          state_d = RESP;
        end
      end
      WR_ISSUE: begin
        if (mem_req_ready) begin
          if (flush_q) begin
            fl_done_d = 1'b1;
            state_d   = DRAIN;
          end else begin
`ifdef L2_MEM_BRIDGE_WB_ACK_EN
            rline_d = '0;
            state_d = RESP;
`else
            state_d = DRAIN;
`endif
          end
        end
      end
      RESP:    state_d = DRAIN;
      FL_REQ:  state_d = FL_WAIT;
      FL_WAIT: begin
        if (fl_match) begin
          wdata_d = cachehier2mem_data;
          flush_d = 1'b1;
          state_d = WR_ISSUE;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are a function of the next state so they leave a flop.
    rvalid_d = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
    rwrite_d = (state_d == WR_ISSUE);
    raddr_d  = rvalid_d ? addr_d : '0;
    rdata_d  = rwrite_d ? wdata_d : '0;
    busy_d   = (state_d != IDLE);
    msg_d    = NO_REQ;
    oaddr_d  = '0;
    odata_d  = '0;
    if (state_d == RESP) begin
      msg_d   = MEM_RESP;
      oaddr_d = addr_d;
      odata_d = rline_d;
    end else if (state_d == FL_REQ) begin
      msg_d   = REQ_FLUSH;
      oaddr_d = addr_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rline_q   <= '0;
      flush_q   <= 1'b0;
      msg_q     <= NO_REQ;
      oaddr_q   <= '0;
      odata_q   <= '0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rwrite_q  <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      fl_rdy_q  <= 1'b0;
      fl_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rline_q   <= rline_d;
      flush_q   <= flush_d;
      msg_q     <= msg_d;
      oaddr_q   <= oaddr_d;
      odata_q   <= odata_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
      rwrite_q  <= rwrite_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      fl_rdy_q  <= fl_rdy_d;
      fl_done_q <= fl_done_d;
    end
  end

  assign mem2cachehier_msg      = msg_q;
  assign mem2cachehier_address  = oaddr_q;
  assign mem2cachehier_data     = odata_q;
  assign mem_intf_busy          = busy_q;
  assign mem_intf_address_valid = busy_q;
  assign mem_intf_address       = addr_q;
  assign mem_req_valid          = rvalid_q;
  assign mem_req_write          = rwrite_q;
  assign mem_req_address        = raddr_q;
  assign mem_req_data           = rdata_q;
  assign ext_flush_ready        = fl_rdy_q;
  assign ext_flush_done         = fl_done_q;

endmodule
